// File: rtl/uart_pkg.sv
// Shared state encoding, frame constants and baud divisor helper for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam int DATA_BITS  = 8;
    localparam int OS_RATE    = 16;
    localparam int MID_SAMPLE = 7;

    // Nearest-integer oversample divisor for baud = 2400 << sel.
    function automatic int unsigned os_div(input int unsigned clk_hz, input logic [1:0] sel);
        int unsigned baud;
        baud = 32'd2400 << sel;
        return (clk_hz + (OS_RATE * baud) / 2) / (OS_RATE * baud);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// 16x oversample tick divider; counter is held at zero while en is low.
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] sel,
    output logic       tick
);
    localparam int unsigned CW = $clog2(os_div(CLK_HZ, 2'd0) + 1);

    localparam logic [CW-1:0] LAST0 = CW'(os_div(CLK_HZ, 2'd0) - 1);
    localparam logic [CW-1:0] LAST1 = CW'(os_div(CLK_HZ, 2'd1) - 1);
    localparam logic [CW-1:0] LAST2 = CW'(os_div(CLK_HZ, 2'd2) - 1);
    localparam logic [CW-1:0] LAST3 = CW'(os_div(CLK_HZ, 2'd3) - 1);

    logic [CW-1:0] cnt_q, cnt_d, last;

    always_comb begin
        case (sel)
            2'd0: last = LAST0;
            2'd1: last = LAST1;
            2'd2: last = LAST2;
            2'd3: last = LAST3;
        endcase
    end

    assign tick = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Strobes are registered and appear the clock after the mid-stop-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_sel,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    logic [1:0]           sync_q;
    logic                 rx_s, tick, tick_en, sample;
    state_e               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           os_q, os_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, pbad_q, pbad_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    assign tick_en = (state_q != IDLE);

    uart_rx_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .sel   (sel_q),
        .tick  (tick)
    );

    assign sample = tick && (os_q == 4'(OS_RATE - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        os_d    = tick ? os_q + 4'd1 : os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        pbad_d  = pbad_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                os_d   = '0;
                bit_d  = '0;
                pbad_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                    sel_d   = baud_sel;
                end
            end
            // A start bit still low at its middle is real; otherwise it was a glitch.
            START: if (tick && os_q == 4'(MID_SAMPLE)) begin
                os_d    = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (sample) begin
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample) begin
                pbad_d  = (rx_s != ^shift_q);
                state_d = STOP;
            end
`endif
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            STOP: if (sample) begin
                dout_d  = shift_q;
                valid_d = rx_s && !pbad_q;
                ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
                perr_d  = pbad_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            pbad_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            pbad_q  <= pbad_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model queues expected strobes and one
// compare loop checks every cycle against it.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1_000_000;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Ticks from start edge to mid stop bit: 8 + 16 per data/parity/stop bit.
    localparam int FRAME_TICKS = PAR_EN ? 168 : 152;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] baud_sel = 2'b10;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, parity_err, busy;

    typedef struct {
        logic [7:0]  b;
        bit          v, fe, pe;
        int unsigned t0, lo, hi;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [7:0]  model_last = 8'h00;
    int unsigned last_lat = 0;
    int unsigned cyc = 0;
    int          n_chk = 0, n_fail = 0;
    bit          strobe, prev_strobe = 1'b0;
    int          bauds[4] = '{2400, 4800, 9600, 19200};
    int          exp50[4] = '{1302, 651, 326, 163};
    int          exp1m[4] = '{26, 13, 7, 3};
    logic [7:0]  abort_byte = 8'hA5;

    uart_rx #(.CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_sel   (baud_sel),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_div(input int unsigned hz, input int baud);
        return (2 * hz + 16 * baud) / (32 * baud);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int unsigned act, input int unsigned lo, input int unsigned hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic bit_out(input bit b, input int d);
        rx = b;
        repeat (16 * d) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop, input bit par_flip, input int d);
        exp_t x;
        bit   par_ok;
        par_ok = PAR_EN ? !par_flip : 1'b1;
        x.b  = b;
        x.v  = stop && par_ok;
        x.fe = !stop;
        x.pe = !par_ok;
        x.t0 = cyc;
        x.lo = FRAME_TICKS * d + 2;
        x.hi = FRAME_TICKS * d + 4;
        q.push_back(x);
        bit_out(1'b0, d);
        for (int i = 0; i < 8; i++) bit_out(b[i], d);
        if (PAR_EN) bit_out((^b) ^ par_flip, d);
        bit_out(stop, d);
        rx = 1'b1;
    endtask

    initial begin
        fork
            begin : compare
                forever begin
                    @(negedge clk);
                    strobe = data_valid | frame_err | parity_err;
                    if (reset) begin
                        if (strobe) begin
                            check("strobe width", {31'd0, prev_strobe}, 32'd0);
                            if (q.size() == 0) begin
                                check("unexpected strobe", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
                            end else begin
                                e = q.pop_front();
                                model_last = e.b;
                                last_lat   = cyc - e.t0;
                                check("strobe kind", {29'd0, data_valid, frame_err, parity_err},
                                      {29'd0, e.v, e.fe, e.pe});
                                check_rng("strobe latency", last_lat, e.lo, e.hi);
                            end
                        end
                        check("data_out hold", {24'd0, data_out}, {24'd0, model_last});
                        if (q.size() > 0 && cyc - q[0].t0 > q[0].hi) begin
                            check_rng("missing strobe", cyc - q[0].t0, q[0].lo, q[0].hi);
                            void'(q.pop_front());
                        end
                    end
                    prev_strobe = strobe;
                end
            end
            begin : stimulus
                for (int i = 0; i < 4; i++) begin
                    check("os_div 50MHz", os_div(32'd50_000_000, 2'(i)), exp50[i]);
                    check("os_div bench clk", os_div(CLK_HZ, 2'(i)), exp1m[i]);
                    check("model divisor", model_div(CLK_HZ, bauds[i]), exp1m[i]);
                end

                repeat (3) @(posedge clk);
                #1;
                check("reset data_out", {24'd0, data_out}, 32'h00);
                check("reset strobes", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
                check("reset busy", {31'd0, busy}, 32'd0);
                reset = 1'b1;
                idle(5);

                // 9600 baud single frame
                baud_sel = 2'b10;
                send(8'hA5, 1'b1, 1'b0, 7);
                idle(8);
                check("A5 data_out", {24'd0, data_out}, 32'hA5);
                check("A5 busy after", {31'd0, busy}, 32'd0);
                check("A5 latency", last_lat, PAR_EN ? 32'd1179 : 32'd1067);

                // start glitch shorter than half a bit
                rx = 1'b0;
                repeat (3 * 7) @(posedge clk);
                #1;
                check("glitch busy", {31'd0, busy}, 32'd1);
                idle(16 * 7 * 2);
                check("glitch idle", {31'd0, busy}, 32'd0);

                // back-to-back at 19200
                baud_sel = 2'b11;
                send(8'h00, 1'b1, 1'b0, 3);
                send(8'hFF, 1'b1, 1'b0, 3);
                send(8'h3C, 1'b1, 1'b0, 3);
                idle(16 * 3 * 4);
                check("b2b last byte", {24'd0, data_out}, 32'h3C);
                check("b2b drained", q.size(), 32'd0);

                // stop bit low at 4800
                baud_sel = 2'b01;
                send(8'h55, 1'b0, 1'b0, 13);
                idle(16 * 13 * 2);
                check("ferr data_out", {24'd0, data_out}, 32'h55);
                check("ferr busy", {31'd0, busy}, 32'd0);

                // baud_sel changed mid-frame only affects the next frame
                baud_sel = 2'b10;
                fork
                    send(8'hC3, 1'b1, 1'b0, 7);
                    begin
                        repeat (16 * 7 * 4) @(posedge clk);
                        #1;
                        baud_sel = 2'b00;
                    end
                join
                send(8'h81, 1'b1, 1'b0, 26);
                idle(16 * 26);
                check("2400 data_out", {24'd0, data_out}, 32'h81);

                // reset in the middle of data bit 4
                baud_sel = 2'b10;
                bit_out(1'b0, 7);
                for (int i = 0; i < 4; i++) bit_out(abort_byte[i], 7);
                rx = abort_byte[4];
                repeat (8 * 7) @(posedge clk);
                #1;
                check("busy before abort", {31'd0, busy}, 32'd1);
                reset = 1'b0;
                rx = 1'b1;
                model_last = 8'h00;
                #1;
                check("abort data_out", {24'd0, data_out}, 32'h00);
                check("abort busy", {31'd0, busy}, 32'd0);
                check("abort strobes", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
                @(posedge clk);
                #1;
                reset = 1'b1;
                idle(16 * 7 * 12);
                check("abort idle", {31'd0, busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
                // even parity of 8'h07 is 1; send 0
                send(8'h07, 1'b1, 1'b1, 7);
                idle(16 * 7 * 2);
                check("parity data_out", {24'd0, data_out}, 32'h07);
`endif

                check("queue drained", q.size(), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        join
    end

endmodule
